// File: rtl/mem_port_arbiter.sv
// N-to-1 data-memory port arbiter with a registered output stage
// and an in-order tag FIFO that routes read responses back to their port.
module mem_port_arbiter #(
    parameter int N_PORTS         = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_PORTS-1:0]                  req_valid,
    output logic [N_PORTS-1:0]                  req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]           req_addr,
    input  logic [N_PORTS*(DATA_W/8)-1:0]       req_do_read,
    input  logic [N_PORTS*(DATA_W/8)-1:0]       req_do_write,
    input  logic [N_PORTS*DATA_W-1:0]           req_data,
    output logic [N_PORTS-1:0]                  rsp_valid,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic [ADDR_W-1:0]                   rsp_addr,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [ADDR_W-1:0]                   mem_req_addr,
    output logic [DATA_W/8-1:0]                 mem_req_do_read,
    output logic [DATA_W/8-1:0]                 mem_req_do_write,
    output logic [DATA_W-1:0]                   mem_req_data,
    input  logic                                mem_rsp_valid,
    input  logic [DATA_W-1:0]                   mem_rsp_data,
    input  logic [ADDR_W-1:0]                   mem_rsp_addr,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                rsp_orphan
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int AW   = $clog2(MAX_OUTSTANDING);
    localparam int CW   = AW + 1;

    logic [PW-1:0]      last_grant;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_addr;
    logic [BE_W-1:0]    out_rd;
    logic [BE_W-1:0]    out_wr;
    logic [DATA_W-1:0]  out_data;

    logic [PW-1:0]      fifo_mem [MAX_OUTSTANDING];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    logic               can_load;
    logic               full;
    logic               push;
    logic               pop;
    logic [N_PORTS-1:0] elig;
    logic [N_PORTS-1:0] grant;
    logic               gvalid;
    logic [PW-1:0]      gidx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BE_W-1:0]    sel_rd;
    logic [BE_W-1:0]    sel_wr;
    logic [DATA_W-1:0]  sel_data;

    // Eligibility: reads need a free tag slot (pre-pop count), writes never do
    always_comb begin
        full     = (count == CW'(MAX_OUTSTANDING));
        can_load = !out_valid || mem_req_ready;
        elig     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            elig[i] = req_valid[i] &&
                      ((req_do_read[i*BE_W +: BE_W] == '0) || !full);
        end
    end

    // Pick one eligible port, rotating from last_grant+1 or by fixed priority
    always_comb begin : sel
        int p;
        p      = 0;
        gvalid = 1'b0;
        gidx   = '0;
        if (can_load) begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (FIXED_PRIORITY != 0) p = k;
                else p = (int'(last_grant) + 1 + k) % N_PORTS;
                if (!gvalid && |(elig & (N_PORTS'(1) << p))) begin
                    gvalid = 1'b1;
                    gidx   = PW'(p);
                end
            end
        end
        grant = gvalid ? (N_PORTS'(1) << gidx) : '0;
    end

    // Route the granted port's request fields to the output stage
    always_comb begin
        sel_addr = '0;
        sel_rd   = '0;
        sel_wr   = '0;
        sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_rd   = req_do_read[i*BE_W +: BE_W];
                sel_wr   = req_do_write[i*BE_W +: BE_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        push = gvalid && (sel_rd != '0);
        pop  = mem_rsp_valid && (count != '0);
    end

    // Output register and arbitration pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_rd     <= '0;
            out_wr     <= '0;
            out_data   <= '0;
            last_grant <= PW'(N_PORTS - 1);
        end else if (gvalid) begin
            out_valid  <= 1'b1;
            out_addr   <= sel_addr;
            out_rd     <= sel_rd;
            out_wr     <= sel_wr;
            out_data   <= sel_data;
            last_grant <= gidx;
        end else if (mem_req_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Tag storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= gidx;
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Registered response routing and sticky orphan flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            rsp_valid <= pop ? (N_PORTS'(1) << fifo_mem[rd_ptr]) : '0;
            if (pop) begin
                rsp_data <= mem_rsp_data;
                rsp_addr <= mem_rsp_addr;
            end
            if (mem_rsp_valid && (count == '0)) rsp_orphan <= 1'b1;
        end
    end

    assign req_ready        = grant;
    assign mem_req_valid    = out_valid;
    assign mem_req_addr     = out_addr;
    assign mem_req_do_read  = out_rd;
    assign mem_req_do_write = out_wr;
    assign mem_req_data     = out_data;
    assign outstanding      = count;

endmodule
